// File: rtl/pi_digit_stream.sv
// Pi digit source: fetches packed digit words from a latency-ROM_LAT ROM into a
// credit-guarded prefetch FIFO and streams them MSB-first as single digits.
// Optional running digit sum enabled by `define PI_DIGIT_CHECKSUM_EN.
module pi_digit_stream #(
    parameter int unsigned        ADDR_W     = 24,
    parameter int unsigned        DIGIT_W    = 4,
    parameter int unsigned        DIGITS_PW  = 9,
    parameter int unsigned        ROM_LAT    = 3,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  LAST_ADDR  = '1,
    localparam int unsigned       DATA_W     = DIGIT_W * DIGITS_PW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                stop,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_q,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [DIGIT_W-1:0]  d_digit,
    output logic [31:0]         d_index,
    output logic                wrapped,
    output logic                busy,
    output logic [15:0]         chk_sum
);

    localparam int unsigned PTR_W  = (DIGITS_PW > 1) ? $clog2(DIGITS_PW) : 1;
    localparam int unsigned FPTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = FPTR_W + 1;
    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + ROM_LAT + 1) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                flush_c;
    logic                issue_c;
    logic                fifo_wr_c;
    logic                fifo_ne_c;
    logic                take_c;
    logic                pop_c;
    logic                accept_c;
    logic [ROM_LAT-1:0]  issue_sr;
    logic [ROM_LAT-1:0]  issue_sr_next_c;
    logic [CRED_W-1:0]   inflight_c;
    logic [CRED_W-1:0]   credit_used_c;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FPTR_W-1:0]   wr_ptr;
    logic [FPTR_W-1:0]   rd_ptr;
    logic [FCNT_W-1:0]   fifo_cnt;
    logic [PTR_W-1:0]    dig_ptr;
    logic [DATA_W-1:0]   head_word_c;
    logic [DIGIT_W-1:0]  head_digits [DIGITS_PW];
    logic [DIGIT_W-1:0]  head_digit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // start beats stop; either one flushes the whole pipeline
    always_comb begin
        state_d = state_q;
        flush_c = 1'b0;
        issue_c = 1'b0;
        if (start) begin
            state_d = S_RUN;
            flush_c = 1'b1;
        end else if (stop) begin
            state_d = S_IDLE;
            flush_c = 1'b1;
        end else if (state_q == S_RUN) begin
            issue_c = credit_used_c < CRED_W'(FIFO_DEPTH);
        end
    end

    // Reads in flight plus buffered words never exceed the FIFO size
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(ROM_LAT); i++) begin
            inflight_c = inflight_c + CRED_W'(issue_sr[i]);
        end
    end

    assign credit_used_c = CRED_W'(fifo_cnt) + inflight_c;
    assign fifo_wr_c     = issue_sr[ROM_LAT-1];
    assign fifo_ne_c     = (fifo_cnt != '0);
    assign accept_c      = d_valid & d_ready;
    assign take_c        = !flush_c && fifo_ne_c && (!d_valid || d_ready);
    assign pop_c         = take_c && (dig_ptr == PTR_W'(DIGITS_PW - 1));

    always_comb begin
        issue_sr_next_c    = '0;
        issue_sr_next_c[0] = issue_c;
        for (int i = 1; i < int'(ROM_LAT); i++) begin
            issue_sr_next_c[i] = issue_sr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       issue_sr <= '0;
        else if (flush_c) issue_sr <= '0;
        else              issue_sr <= issue_sr_next_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            wrapped  <= 1'b0;
        end else if (start) begin
            rom_addr <= start_addr;
            wrapped  <= 1'b0;
        end else if (issue_c) begin
            if (rom_addr == LAST_ADDR) begin
                rom_addr <= '0;
                wrapped  <= 1'b1;
            end else begin
                rom_addr <= rom_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr_c && !flush_c) fifo_mem[wr_ptr] <= rom_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_c) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + FPTR_W'(fifo_wr_c);
            rd_ptr   <= rd_ptr + FPTR_W'(pop_c);
            fifo_cnt <= fifo_cnt + FCNT_W'(fifo_wr_c) - FCNT_W'(pop_c);
        end
    end

    // The FIFO head is the unpacker word; it pops as its last digit leaves
    assign head_word_c = fifo_mem[rd_ptr];
    for (genvar k = 0; k < DIGITS_PW; k++) begin : g_unpack
        assign head_digits[k] = head_word_c[DATA_W-1-k*DIGIT_W -: DIGIT_W];
    end
    assign head_digit_c = head_digits[dig_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_ptr <= '0;
            d_valid <= 1'b0;
            d_digit <= '0;
        end else if (flush_c) begin
            dig_ptr <= '0;
            d_valid <= 1'b0;
            d_digit <= '0;
        end else if (!d_valid || d_ready) begin
            d_valid <= fifo_ne_c;
            if (take_c) begin
                d_digit <= head_digit_c;
                dig_ptr <= pop_c ? '0 : dig_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        d_index <= '0;
        else if (start)    d_index <= '0;
        else if (accept_c) d_index <= d_index + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= 1'b0;
        else        busy <= (state_d == S_RUN);
    end

`ifdef PI_DIGIT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        chk_sum <= '0;
        else if (start)    chk_sum <= '0;
        else if (accept_c) chk_sum <= chk_sum + 16'(d_digit);
    end
`else
    assign chk_sum = '0;
`endif

endmodule

// File: tb/tb_pi_digit_stream.sv
// Scoreboard bench for pi_digit_stream: expected digits are queued from a ROM
// model on each start and retired as the consumer accepts digits.
module tb_pi_digit_stream;

    localparam int unsigned       ADDR_W     = 24;
    localparam int unsigned       DIGIT_W    = 4;
    localparam int unsigned       DIGITS_PW  = 9;
    localparam int unsigned       ROM_LAT    = 3;
    localparam int unsigned       FIFO_DEPTH = 4;
    localparam int unsigned       DATA_W     = DIGIT_W * DIGITS_PW;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = 24'd3;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   start_addr;
    logic                stop;
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_q;
    logic                d_valid;
    logic                d_ready;
    logic [DIGIT_W-1:0]  d_digit;
    logic [31:0]         d_index;
    logic                wrapped;
    logic                busy;
    logic [15:0]         chk_sum;

    pi_digit_stream #(
        .ADDR_W     (ADDR_W),
        .DIGIT_W    (DIGIT_W),
        .DIGITS_PW  (DIGITS_PW),
        .ROM_LAT    (ROM_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LAST_ADDR  (LAST_ADDR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_digit    (d_digit),
        .d_index    (d_index),
        .wrapped    (wrapped),
        .busy       (busy),
        .chk_sum    (chk_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with three cycles from address to data
    logic [DATA_W-1:0] rom_mem [4];
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    always @(posedge clk) begin
        ra1   <= rom_addr;
        ra2   <= ra1;
        rom_q <= rom_mem[ra2[1:0]];
    end

    logic [3:0]  exp_q [$];
    int          n_checks;
    int          n_fail;
    int          n_acc;
    int          acc_limit;
    int          ready_mode;
    int unsigned exp_idx;
    logic [15:0] exp_sum;
    logic        prev_stall;
    logic [3:0]  prev_digit;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [ADDR_W-1:0] a0, input int nwords);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        a = a0;
        for (int n = 0; n < nwords; n++) begin
            w = rom_mem[a[1:0]];
            for (int k = 0; k < int'(DIGITS_PW); k++) begin
                exp_q.push_back(w[DATA_W-1 -: 4]);
                w = w << 4;
            end
            a = (a == LAST_ADDR) ? '0 : a + 24'd1;
        end
    endtask

    task automatic sample();
        logic [3:0] e;
        if (prev_stall) begin
            check_eq("stall_valid", 64'(d_valid), 64'd1);
            check_eq("stall_digit", 64'(d_digit), 64'(prev_digit));
        end
        if (d_valid && d_ready && !start && rst_n) begin
            check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("digit", 64'(d_digit), 64'(e));
                check_eq("d_index", 64'(d_index), 64'(exp_idx));
                check_eq("chk_sum", 64'(chk_sum), 64'(exp_sum));
                exp_idx++;
`ifdef PI_DIGIT_CHECKSUM_EN
                exp_sum = exp_sum + 16'(e);
`endif
            end
            n_acc++;
        end
        prev_stall = d_valid && !d_ready && !start && !stop && rst_n;
        prev_digit = d_digit;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       d_ready = 1'b0;
            1:       d_ready = (n_acc < acc_limit);
            default: d_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input int nwords);
        exp_q.delete();
        push_stream(a, nwords);
        exp_idx    = 0;
        exp_sum    = '0;
        n_acc      = 0;
        start_addr = a;
        start      = 1'b1;
        cycle();
        start      = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_acc(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (n_acc < target && c < budget) begin
            cycle();
            c++;
        end
        check_eq(tag, 64'(n_acc >= target), 64'd1);
    endtask

    logic [ADDR_W-1:0] last_addr;
    int                chg;

    initial begin
        rom_mem[0] = 36'h314159265;
        rom_mem[1] = 36'h358979323;
        rom_mem[2] = 36'h846264338;
        rom_mem[3] = 36'h327950288;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; start_addr = '0; d_ready = 1'b0;
        ready_mode = 0; acc_limit = 0; prev_stall = 1'b0; prev_digit = '0;
        n_checks = 0; n_fail = 0; n_acc = 0; exp_idx = 0; exp_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rom_addr", 64'(rom_addr), 64'd0);
        check_eq("rst_d_valid", 64'(d_valid), 64'd0);
        check_eq("rst_d_digit", 64'(d_digit), 64'd0);
        check_eq("rst_d_index", 64'(d_index), 64'd0);
        check_eq("rst_wrapped", 64'(wrapped), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_chk_sum", 64'(chk_sum), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Full-rate stream from word 0, then first digit latency
        ready_mode = 1; acc_limit = 1 << 30; d_ready = 1'b1;
        do_start(24'd0, 130);
        check_eq("busy_run", 64'(busy), 64'd1);
        check_eq("valid_after_start", 64'(d_valid), 64'd0);
        repeat (ROM_LAT + 1) cycle();
        check_eq("latency_early", 64'(d_valid), 64'd0);
        cycle();
        check_eq("latency_valid", 64'(d_valid), 64'd1);
        check_eq("first_digit", 64'(d_digit), 64'd3);
        repeat (18) cycle();
        check_eq("sustained_rate", 64'(n_acc), 64'd18);

        // Random backpressure over a long run
        ready_mode = 2;
        wait_acc(1018, 8000, "random_drain");

        // Stop flushes output but keeps counters
        ready_mode = 1;
        do_stop();
        check_eq("stop_valid", 64'(d_valid), 64'd0);
        check_eq("stop_busy", 64'(busy), 64'd0);
        check_eq("stop_index_hold", 64'(d_index), 64'(exp_idx));
        check_eq("stop_wrapped_hold", 64'(wrapped), 64'd1);
        check_eq("stop_sum_hold", 64'(chk_sum), 64'(exp_sum));
        last_addr = rom_addr;
        repeat (20) cycle();
        check_eq("stop_addr_hold", 64'(rom_addr), 64'(last_addr));
        check_eq("stop_quiet", 64'(d_valid), 64'd0);

        // Consumer stalled: only FIFO_DEPTH fetches may be issued
        ready_mode = 0; d_ready = 1'b0;
        do_start(24'd0, 20);
        chg = 0;
        last_addr = rom_addr;
        repeat (30) begin
            cycle();
            if (rom_addr != last_addr) chg++;
            last_addr = rom_addr;
        end
        check_eq("stall_fetch_count", 64'(chg), 64'(FIFO_DEPTH));
        check_eq("stall_held_valid", 64'(d_valid), 64'd1);
        check_eq("stall_held_digit", 64'(d_digit), 64'd3);
        ready_mode = 1;
        wait_acc(60, 300, "resume_drain");

        // Address wrap past LAST_ADDR
        do_start(24'd2, 10);
        check_eq("wrap_a0", 64'(rom_addr), 64'd2);
        check_eq("wrap_clear", 64'(wrapped), 64'd0);
        cycle();
        check_eq("wrap_a1", 64'(rom_addr), 64'd3);
        check_eq("wrap_pre", 64'(wrapped), 64'd0);
        cycle();
        check_eq("wrap_a2", 64'(rom_addr), 64'd0);
        check_eq("wrap_set", 64'(wrapped), 64'd1);
        cycle();
        check_eq("wrap_a3", 64'(rom_addr), 64'd1);
        wait_acc(30, 200, "wrap_drain");

        // Restart with two reads outstanding: stale words must vanish
        do_start(24'd0, 10);
        repeat (2) cycle();
        do_start(24'd1, 10);
        wait_acc(20, 200, "restart_drain");

        // Checksum over exactly the first nine digits
        acc_limit = 9;
        do_start(24'd0, 10);
        wait_acc(9, 200, "sum_drain");
        repeat (3) cycle();
        check_eq("sum_index", 64'(d_index), 64'd9);
`ifdef PI_DIGIT_CHECKSUM_EN
        check_eq("sum_first_word", 64'(chk_sum), 64'd36);
`else
        check_eq("sum_disabled", 64'(chk_sum), 64'd0);
`endif

        // Asynchronous reset in the middle of a stream
        acc_limit = 1 << 30; ready_mode = 2;
        do_start(24'd1, 20);
        wait_acc(25, 400, "pre_reset_drain");
        rst_n = 1'b0;
        prev_stall = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(d_valid), 64'd0);
        check_eq("mid_rst_index", 64'(d_index), 64'd0);
        check_eq("mid_rst_addr", 64'(rom_addr), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_sum", 64'(chk_sum), 64'd0);
        check_eq("mid_rst_wrapped", 64'(wrapped), 64'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        exp_q.delete();
        ready_mode = 1;
        repeat (20) cycle();
        check_eq("post_rst_valid", 64'(d_valid), 64'd0);
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_eq("post_rst_addr", 64'(rom_addr), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
